mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-port memory arbiter and sequencer for the multicycle RISC-V core.
- Shares one unified instruction/data memory port between two requesters: the instruction-fetch path (control unit FETCH) and the load/store data path.
- Owns the memory handshake, including variable wait states, and returns read data plus a one-cycle done pulse to the winning requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum wait cycles per access. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; hold until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction
- if_done  out  1  one-cycle completion pulse
- d_req  in  1  data request; hold until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables for stores
- d_rdata  out  DATA_W  load data
- d_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  access completes this cycle when mem_en=1
- busy  out  1  1 when state is not IDLE
- mem_err  out  1  timeout flag, pulses together with done

Behaviour:
- Reset (sync, active-high):
  - state = IDLE; all outputs 0 (mem_*, if_*/d_* rdata and done, busy, mem_err).
  - last_grant = DATA, so the first contended grant goes to fetch.
  - Reset mid-access abandons the access with no done pulse.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - Qualified requests: if_req & ~if_done, and d_req & ~d_done. A requester whose done is high this cycle is ignored.
  - Only one qualified request: grant it.
  - Both qualified: grant the requester opposite to last_grant (alternating on contention).
  - On the grant edge, latch address, we, wdata and be into the mem_* registers; set mem_en=1; update last_grant; enter BUSY_x.
  - Fetch grants drive mem_we=0 and mem_be all ones.
- BUSY_x:
  - Hold mem_* stable while mem_ready=0.
  - At an edge where mem_en & mem_ready: x_done <= 1 for exactly one cycle; for reads, x_rdata <= mem_rdata; mem_en <= 0; mem_we <= 0; state -> IDLE.
  - Stores leave d_rdata unchanged.
- Timing:
  - Zero-wait memory (mem_ready in first BUSY cycle): req seen cycle 0, mem_en cycle 1, done cycle 2.
  - Each wait state adds 1 cycle.
  - Maximum throughput: one access per 2 cycles, since IDLE is a mandatory bubble.
- Requester rules:
  - Drop req in the cycle done is high, or re-raise it with new fields; the arbiter sees it no earlier than the next cycle.
  - Changes to request fields after the grant edge are ignored.
- mem_ready while mem_en=0 is ignored.
- Only one done is ever high per cycle.
- rdata holds its value until the next read completes for that requester.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on grant and increments each BUSY cycle with mem_ready=0.
  - When it reaches TIMEOUT, abort: x_done=1 and mem_err=1 for one cycle; rdata for a load is forced to 0; mem_en drops; state -> IDLE.
  - If mem_ready arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins: normal completion, mem_err=0.
- Undefined: no counter; waits indefinitely; mem_err is tied to 0.

Decomposition:
- Package riscv_mem_pkg:
  - arbiter state encoding (IDLE, BUSY_IF, BUSY_D);
  - grant-owner encoding (GNT_IF, GNT_D);
  - default ADDR_W/DATA_W constants;
  - fetch full byte-enable constant.
- Sub-module mem_timeout_ctr (counter plus expiry flag), instantiated only under MEM_TIMEOUT_EN.
- Arbitration and FSM logic stay in mem_arbiter.

Test Plan:
- Zero-wait fetch:
  - Stimulus: reset, then if_req=1, if_addr=0x00000010; memory returns 0x00500093 with mem_ready in the first BUSY cycle.
  - Expected: mem_en high cycle 1 with mem_addr=0x10, mem_we=0; if_done cycle 2; if_rdata=0x00500093.
- Store with 3 wait states:
  - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011.
  - Expected: mem_* stable for 4 cycles; d_done at cycle 5; d_rdata unchanged.
- Contention:
  - Stimulus: if_req and d_req raised together after reset, then held (re-raised) through 3 grants.
  - Expected: grant order IF, D, IF; last_grant alternates.
- Reset mid-access:
  - Stimulus: reset asserted during a BUSY_D wait state.
  - Expected: next cycle state IDLE, mem_en=0, no d_done; a fresh d_req completes normally afterwards.
- Done-cycle requester rule:
  - Stimulus: requester keeps req high through its done cycle.
  - Expected: no re-grant in that cycle; re-grant the following cycle.
- MEM_TIMEOUT_EN (TIMEOUT=4):
  - Stimulus: mem_ready never asserted.
  - Expected: d_done and mem_err pulse after 4 wait cycles, d_rdata=0.
  - Stimulus: mem_ready asserted in wait cycle 4.
  - Expected: normal completion, mem_err=0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared encodings and defaults for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

   localparam int ADDR_W_DFLT = 32;
   localparam int DATA_W_DFLT = 32;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_IF = 2'd1;
   localparam logic [1:0] ST_BUSY_D  = 2'd2;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   // Wide enough for any sane DATA_W; users slice the low DATA_W/8 bits.
   localparam logic [127:0] FETCH_BE_ALL = '1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-state counter for one memory access; flags the cycle whose stall would reach TIMEOUT.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expired = inc & (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Optional per-access wait timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DFLT,
   parameter int DATA_W  = DATA_W_DFLT,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                busy,
   output logic                mem_err
);

   localparam int BE_W = DATA_W / 8;

   logic [1:0] state;
   logic       last_grant;
   logic       q_if, q_d, gnt_if, gnt_d;
   logic       in_busy, complete, tmo_expire;

   // A requester whose done is high this cycle is still holding the old request.
   assign q_if    = if_req & ~if_done;
   assign q_d     = d_req & ~d_done;
   assign gnt_if  = q_if & (~q_d | (last_grant == GNT_D));
   assign gnt_d   = q_d & ~gnt_if;
   assign in_busy  = (state != ST_IDLE);
   assign complete = in_busy & mem_en & mem_ready;

`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk     (clk),
      .reset   (reset),
      .clr     (~in_busy),
      .inc     (in_busy & mem_en & ~mem_ready),
      .expired (tmo_expire)
   );
`else
   assign tmo_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= GNT_D;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         if_rdata   <= '0;
         if_done    <= 1'b0;
         d_rdata    <= '0;
         d_done     <= 1'b0;
         busy       <= 1'b0;
         mem_err    <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         mem_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_if) begin
                  state      <= ST_BUSY_IF;
                  last_grant <= GNT_IF;
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_be     <= FETCH_BE_ALL[BE_W-1:0];
                  busy       <= 1'b1;
               end else if (gnt_d) begin
                  state      <= ST_BUSY_D;
                  last_grant <= GNT_D;
                  mem_en     <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  mem_be     <= d_be;
                  busy       <= 1'b1;
               end
            end
            ST_BUSY_IF: begin
               if (complete || tmo_expire) begin
                  if_done  <= 1'b1;
                  if_rdata <= complete ? mem_rdata : '0;
                  mem_err  <= ~complete;
                  mem_en   <= 1'b0;
                  mem_we   <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            ST_BUSY_D: begin
               if (complete || tmo_expire) begin
                  d_done <= 1'b1;
                  // Stores never disturb the last load result.
                  if (!mem_we)
                     d_rdata <= complete ? mem_rdata : '0;
                  mem_err <= ~complete;
                  mem_en  <= 1'b0;
                  mem_we  <= 1'b0;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
